// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the multi-word adder-sharing controller.
package adder_share_pkg;

  localparam int ADD_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_if.sv
// Request/response handshake bundle between client blocks and the adder-sharing controller.
interface adder_share_if
  import adder_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WORDS = 4
) ();

  localparam int OPW = ADD_W * WORDS;
  localparam int IDW = id_w(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_a;
  logic [NREQ*OPW-1:0] req_b;
  logic [NREQ-1:0]     req_sub;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [OPW-1:0]      rsp_sum;
  logic                rsp_cout;
  logic                rsp_ovf;

  // Client side.
  modport master (
    output req_valid, req_a, req_b, req_sub, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  // Controller side.
  modport slave (
    input  req_valid, req_a, req_b, req_sub, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

endinterface

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester after ptr (wrapping) wins. Purely combinational.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  function automatic logic [IDW-1:0] wrap(input logic [IDW-1:0] base, input int step);
    int s;
    s = int'(base) + step;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // ptr itself is searched last, so the previous winner has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_any && req[wrap(ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = wrap(ptr, k);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one external 8-bit adder between NREQ requesters, sequencing WORDS-byte add/sub
// operations LSB byte first with the carry chained through a one-bit register.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  adder_share_if.slave     bus,
  output logic [ADD_W-1:0] add_a,
  output logic [ADD_W-1:0] add_b,
  output logic             add_cin,
  input  logic [ADD_W-1:0] add_sum,
  input  logic             add_cout
);

  localparam int OPW = ADD_W * WORDS;
  localparam int IDW = id_w(NREQ);
  localparam int IXW = id_w(WORDS);
  localparam logic [IXW-1:0] LAST_IDX = IXW'(WORDS - 1);
  localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);

  state_t         state, state_nxt;
  logic [OPW-1:0] a_r, b_r, sum_r;
  logic           sub_r, carry_r, cout_r, ovf_r;
  logic [IDW-1:0] id_r, ptr_r;
  logic [IXW-1:0] idx_r;

  logic [NREQ-1:0] gnt_onehot;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [OPW-1:0]  sel_a, sel_b;
  logic            sel_sub;
  logic            accept;
  logic            last_byte;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (ptr_r),
    .grant     (gnt_onehot),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  always_comb begin
    sel_a   = bus.req_a[int'(gnt_idx)*OPW +: OPW];
    sel_b   = bus.req_b[int'(gnt_idx)*OPW +: OPW];
    sel_sub = bus.req_sub[gnt_idx];
  end

  assign last_byte = (idx_r == LAST_IDX);

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.req_ready = '0;
    add_a         = '0;
    add_b         = '0;
    add_cin       = 1'b0;
    unique case (state)
      IDLE: begin
        // Grant is offered only while out of reset so a held request is never acked early.
        if (!rst) bus.req_ready = gnt_onehot;
        if (gnt_any) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        add_a   = a_r[int'(idx_r)*ADD_W +: ADD_W];
        add_b   = b_r[int'(idx_r)*ADD_W +: ADD_W];
        add_cin = (idx_r == '0) ? sub_r : carry_r;
        if (last_byte) state_nxt = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sub_r   <= 1'b0;
      id_r    <= '0;
      ptr_r   <= PTR_RST;
      idx_r   <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_r   <= sel_a;
        b_r   <= sel_b ^ {OPW{sel_sub}};
        sub_r <= sel_sub;
        id_r  <= gnt_idx;
        ptr_r <= gnt_idx;
        idx_r <= '0;
      end
      if (state == RUN) begin
        sum_r[int'(idx_r)*ADD_W +: ADD_W] <= add_sum;
        carry_r <= add_cout;
        if (last_byte) begin
          cout_r <= add_cout;
          ovf_r  <= signed_ovf(a_r[OPW-1], b_r[OPW-1], add_sum[ADD_W-1]);
        end else begin
          idx_r <= idx_r + 1'b1;
        end
      end
    end
  end

  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_id    = id_r;
  assign bus.rsp_sum   = sum_r;
  assign bus.rsp_cout  = cout_r;
  assign bus.rsp_ovf   = ovf_r;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a behavioural 8-bit adder closing the loop.
module tb_adder_share_ctrl;
  import adder_share_pkg::*;

  localparam int NREQ  = 4;
  localparam int WORDS = 4;
  localparam int OPW   = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp4 [4] = '{32'h12121212, 32'h23232323, 32'h34343434, 32'h45454545};

  adder_share_if #(.NREQ(NREQ), .WORDS(WORDS)) bus ();

  adder_share_ctrl #(.NREQ(NREQ), .WORDS(WORDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic sub);
    bus.req_a[r*OPW +: OPW] = a;
    bus.req_b[r*OPW +: OPW] = b;
    bus.req_sub[r]          = sub;
  endtask

  task automatic run_op(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] es, input logic ec, input logic eo,
                        input logic [3:0] ecin);
    logic [3:0] cin_seq;
    logic       early;
    set_req(r, a, b, sub);
    bus.req_valid    = '0;
    bus.req_valid[r] = 1'b1;
    #1;
    chk({tag, "_grant"}, 64'(bus.req_ready), 64'(1) << r);
    tick();
    bus.req_valid = '0;
    early = 1'b0;
    cin_seq = '0;
    for (int k = 0; k < WORDS; k++) begin
      cin_seq[k] = add_cin;
      early = early | bus.rsp_valid;
      tick();
    end
    chk({tag, "_early"}, 64'(early), 64'(0));
    chk({tag, "_valid"}, 64'(bus.rsp_valid), 64'(1));
    chk({tag, "_id"},    64'(bus.rsp_id), 64'(r));
    chk({tag, "_sum"},   64'(bus.rsp_sum), 64'(es));
    chk({tag, "_cout"},  64'(bus.rsp_cout), 64'(ec));
    chk({tag, "_ovf"},   64'(bus.rsp_ovf), 64'(eo));
    chk({tag, "_cin"},   64'(cin_seq), 64'(ecin));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk({tag, "_idle"},  64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) tick();
    chk("rst_outputs",
        {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf,
         add_a, add_b, add_cin}, 64'(0));
    rst = 1'b0;

    // Basic add, latency, carry chain and subtract/overflow corners.
    run_op("t1",    0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 4'b0010);
    run_op("t2",    1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 4'b1110);
    run_op("t3sub", 2, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 4'b0001);
    run_op("t3neg", 0, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 4'b0001);
    run_op("tmix",  1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 4'b0110);
    run_op("t3pos", 3, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 4'b1110);

    // All requesters held valid: round-robin order starting after requester 3.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h11111111 * (i + 1), 32'h01010101, 1'b0);
    bus.req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      #1;
      chk("t4_grant", 64'(bus.req_ready), 64'(1) << (n % 4));
      tick();
      chk("t4_busy", 64'(bus.req_ready), 64'(0));
      repeat (WORDS) tick();
      chk("t4_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_sum}, {1'b1, 2'(n % 4), exp4[n % 4]});
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end

    // Back-pressure in DONE with another requester waiting.
    set_req(2, 32'h00000003, 32'h00000004, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    chk("t5_grant", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    bus.req_valid = '0;
    repeat (WORDS) tick();
    set_req(1, 32'h00000010, 32'h00000020, 1'b0);
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t5_hold",
          {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf, bus.req_ready},
          {1'b1, 2'd2, 32'h00000007, 1'b0, 1'b0, 4'b0000});
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("t5_release", 64'(bus.rsp_valid), 64'(0));
    #1;
    chk("t5_idle_grant", 64'(bus.req_ready), 64'(4'b0010));
    bus.req_valid = '0;
    #1;
    chk("t5_drop", 64'(bus.req_ready), 64'(0));
    tick();
    chk("t5_not_started", {add_a, add_b, add_cin, bus.rsp_valid}, 64'(0));

    // Reset in the middle of an operation.
    set_req(2, 32'h01020304, 32'h10203040, 1'b0);
    bus.req_valid = 4'b0100;
    #1;
    chk("t6_grant", 64'(bus.req_ready), 64'(4'b0100));
    tick();
    tick();
    tick();
    chk("t6_idx2", {add_a, add_b, add_cin}, {8'h02, 8'h20, 1'b0});
    rst = 1'b1;
    #1;
    chk("t6_rst_outputs",
        {bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf,
         add_a, add_b, add_cin}, 64'(0));
    tick();
    rst = 1'b0;
    run_op("t6", 2, 32'h0A0B0C0D, 32'h01010101, 1'b0, 32'h0B0C0D0E, 1'b0, 1'b0, 4'b0000);

    // After reset the pointer must again favour requester 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    chk("rst_ptr", 64'(bus.req_ready), 64'(4'b0001));
    bus.req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
